// File: rtl/io_out_queue.sv
// io_out_queue - CPU-to-device store path for the memory-mapped IO port.
//
// Lane-aligns a CPU store (byte/half/word at a byte offset) into a 32-bit
// word plus byte strobe, queues it in a DEPTH-entry FIFO and presents the
// head entry to the device over a valid/ready handshake.
//
// Optional feature macro: IO_OUT_ERR_EN
//   defined   : sticky err_overflow / err_misalign flag registers
//   undefined : both flag ports tied to 0, drops are silent
//
// Ports:
//   clock, reset         system clock, async active-high reset
//   store                CPU store request
//   data_type[2:0]       [1:0] size (00 byte, 01 half, 1x word); [2] unused
//   data_offset[1:0]     byte offset within the word
//   cpu_in[31:0]         right-justified store data
//   full, count          FIFO status
//   dev_valid/dev_ready  device handshake
//   dev_data, dev_strb   head entry, lane-aligned data and byte enables
//   err_overflow         sticky: store dropped because FIFO was full
//   err_misalign         sticky: store dropped because it was misaligned
module io_out_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       store,
  input  logic [2:0]                 data_type,
  input  logic [1:0]                 data_offset,
  input  logic [31:0]                cpu_in,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dev_valid,
  output logic [31:0]                dev_data,
  output logic [3:0]                 dev_strb,
  input  logic                       dev_ready,
  output logic                       err_overflow,
  output logic                       err_misalign
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [31:0]   mem_data [DEPTH];
  logic [3:0]    mem_strb [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0] fmt_data;
  logic [3:0]  fmt_strb;
  logic        aligned;
  logic        enq;
  logic        deq;

  // The unsigned flag has no meaning for stores.
  logic unused_type_bit;
  assign unused_type_bit = data_type[2];

  always_comb begin
    fmt_data = cpu_in;
    fmt_strb = 4'b1111;
    aligned  = 1'b1;
    unique case (data_type[1:0])
      2'b00: begin
        fmt_data = {4{cpu_in[7:0]}};
        fmt_strb = 4'b0001 << data_offset;
      end
      2'b01: begin
        fmt_data = {2{cpu_in[15:0]}};
        fmt_strb = 4'b0011 << data_offset;
        aligned  = ~data_offset[0];
      end
      default: begin
        aligned = (data_offset == 2'b00);
      end
    endcase
  end

  assign full      = (count == FULL_CNT);
  assign dev_valid = (count != '0);
  assign enq       = store && !full && aligned;
  assign deq       = dev_valid && dev_ready;
  assign dev_data  = mem_data[rd_ptr];
  assign dev_strb  = mem_strb[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_strb[i] <= '0;
      end
    end else begin
      if (enq) begin
        mem_data[wr_ptr] <= fmt_data;
        mem_strb[wr_ptr] <= fmt_strb;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef IO_OUT_ERR_EN
  logic overflow_q;
  logic misalign_q;

  // Misalignment wins: a misaligned store while full only flags misalign.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (store) begin
      if (!aligned) begin
        misalign_q <= 1'b1;
      end else if (full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign err_overflow = overflow_q;
  assign err_misalign = misalign_q;
`else
  assign err_overflow = 1'b0;
  assign err_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_io_out_queue.sv
// tb_io_out_queue - self-checking bench for io_out_queue (DEPTH=4).
// Directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_io_out_queue;

  localparam int DEPTH = 4;
`ifdef IO_OUT_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        store;
  logic [2:0]  data_type;
  logic [1:0]  data_offset;
  logic [31:0] cpu_in;
  logic        full;
  logic [2:0]  count;
  logic        dev_valid;
  logic [31:0] dev_data;
  logic [3:0]  dev_strb;
  logic        dev_ready;
  logic        err_overflow;
  logic        err_misalign;

  int n_cmp = 0;
  int n_err = 0;

  io_out_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .store(store), .data_type(data_type),
    .data_offset(data_offset), .cpu_in(cpu_in), .full(full), .count(count),
    .dev_valid(dev_valid), .dev_data(dev_data), .dev_strb(dev_strb),
    .dev_ready(dev_ready), .err_overflow(err_overflow),
    .err_misalign(err_misalign)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [35:0] q[$];   // {strb, data}
  bit          m_ovf;
  bit          m_mis;

  function automatic logic [35:0] format_store(input logic [2:0] dt,
                                               input logic [1:0] off,
                                               input logic [31:0] d,
                                               output bit ok);
    int nbytes;
    logic [31:0] od;
    logic [3:0]  os;
    nbytes = (dt[1:0] == 2'b00) ? 1 : (dt[1:0] == 2'b01) ? 2 : 4;
    ok = ((int'(off) % nbytes) == 0);
    for (int i = 0; i < 4; i++) begin
      od[8*i +: 8] = d[8*(i % nbytes) +: 8];
      os[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
    end
    return {os, od};
  endfunction

  always @(posedge reset) begin
    q.delete();
    m_ovf = 1'b0;
    m_mis = 1'b0;
  end

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
    end else begin
      bit          ok;
      bit          was_full;
      logic [35:0] e;
      logic [35:0] tmp;
      was_full = (q.size() == DEPTH);
      e = format_store(data_type, data_offset, cpu_in, ok);
      if (q.size() != 0 && dev_ready) tmp = q.pop_front();
      if (store) begin
        if (!ok) m_mis = ERR;
        else if (was_full) m_ovf = ERR;
        else q.push_back(e);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("count", 32'(count), q.size());
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("dev_valid", 32'(dev_valid), 32'(q.size() != 0));
      chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
      chk("err_misalign", 32'(err_misalign), 32'(m_mis));
      if (q.size() != 0) begin
        chk("dev_data", dev_data, q[0][31:0]);
        chk("dev_strb", 32'(dev_strb), 32'(q[0][35:32]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit st, input logic [2:0] dt, input logic [1:0] off,
                      input logic [31:0] d, input bit rdy);
    store = st; data_type = dt; data_offset = off; cpu_in = d; dev_ready = rdy;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    store = 1'b0; dev_ready = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    store = 1'b0; data_type = 3'b000; data_offset = 2'b00;
    cpu_in = 32'h0; dev_ready = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(dev_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_data", dev_data, 0);
    chk("rst_strb", 32'(dev_strb), 0);
    chk("rst_flags", 32'({err_overflow, err_misalign}), 0);
    @(negedge clock);
    #1;
    reset = 1'b0;

    // Byte store at offset 2.
    step(1, 3'b000, 2'd2, 32'h000000A5, 0);
    chk("byte_valid", 32'(dev_valid), 1);
    chk("byte_data", dev_data, 32'hA5A5A5A5);
    chk("byte_strb", 32'(dev_strb), 32'b0100);
    chk("byte_count", 32'(count), 1);
    step(0, 3'b000, 2'd0, 32'h0, 1);
    chk("byte_drained", 32'(count), 0);

    // Half then word, then drain.
    step(1, 3'b101, 2'd2, 32'h1234BEEF, 0);
    step(1, 3'b010, 2'd0, 32'hCAFEF00D, 0);
    chk("half_data", dev_data, 32'hBEEFBEEF);
    chk("half_strb", 32'(dev_strb), 32'b1100);
    step(0, 3'b000, 2'd0, 32'h0, 1);
    chk("word_data", dev_data, 32'hCAFEF00D);
    chk("word_strb", 32'(dev_strb), 32'b1111);
    step(0, 3'b000, 2'd0, 32'h0, 1);
    chk("hw_valid", 32'(dev_valid), 0);
    chk("hw_count", 32'(count), 0);

    // Overfill with 5 words.
    for (int i = 1; i <= 5; i++) begin
      step(1, 3'b010, 2'd0, 32'(i), 0);
      if (i == 4) chk("fill_full", 32'(full), 1);
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_ovf", 32'(err_overflow), 32'(ERR));
    for (int i = 1; i <= 4; i++) begin
      chk("fill_drain", dev_data, 32'(i));
      step(0, 3'b000, 2'd0, 32'h0, 1);
    end
    chk("fill_empty", 32'(dev_valid), 0);

    // Store while full with simultaneous dequeue.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 3'b010, 2'd0, 32'h10 + 32'(i), 0);
    step(1, 3'b010, 2'd0, 32'h99, 1);
    chk("fulldq_count", 32'(count), 3);
    chk("fulldq_ovf", 32'(err_overflow), 32'(ERR));
    chk("fulldq_head", dev_data, 32'h12);
    // Misaligned while full: only the misalign flag may rise.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 3'b010, 2'd0, 32'(i), 0);
    step(1, 3'b001, 2'd1, 32'h55, 0);
    chk("misfull_mis", 32'(err_misalign), 32'(ERR));
    chk("misfull_ovf", 32'(err_overflow), 0);

    // Misaligned half and word.
    do_reset();
    step(1, 3'b001, 2'd1, 32'h1111, 0);
    step(1, 3'b010, 2'd3, 32'h2222, 0);
    chk("mis_count", 32'(count), 0);
    chk("mis_flag", 32'(err_misalign), 32'(ERR));
    chk("mis_ovf", 32'(err_overflow), 0);

    // Streaming through pointer wrap, then async reset mid-stream.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 3'b010, 2'd0, 32'hA000 + 32'(i), 1);
      chk("stream_le1", 32'(count <= 3'd1), 1);
      if (i > 0) chk("stream_order", dev_data, 32'hA000 + 32'(i));
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(dev_valid), 0);
    chk("async_count", 32'(count), 0);
    @(negedge clock);
    #1;
    reset = 1'b0;

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      if (i % 150 == 149) begin
        do_reset();
      end else begin
        rdy = ((i / 50) % 2 == 0) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
        step($urandom % 3 != 0, 3'($urandom % 8), 2'($urandom % 4), $urandom, rdy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
